ysyx_22050058_lsu: RTL and testbench

Load/store unit between the execute stage and the data memory. Accepts one instruction at a time from EX over a valid/ready handshake, and issues a one-cycle read or write request to the data memory. For writes it aligns store data and the byte mask to the 8-byte line. For reads it extracts, sign- or zero-extends the returned data, and hands the result to write-back over a second valid/ready handshake. Non-memory instructions pass through with one cycle of latency.

---
 rtl/ysyx_22050058_lsu_if.sv | 49 ++++
 rtl/ysyx_22050058_lsu.sv | 177 +++++++++++++++++
 tb/tb_ysyx_22050058_lsu.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050058_lsu_if.sv
// Bundle of the LSU's EX-side, WB-side and data-memory signals.
// The master modport is the LSU's view; the slave modport is the surrounding pipeline and memory.
interface ysyx_22050058_lsu_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic                  ex_valid;
    logic                  ex_ready;
    logic                  ex_load;
    logic                  ex_store;
    logic [2:0]            ex_funct3;
    logic [ADDR_W-1:0]     ex_addr;
    logic [DATA_W-1:0]     ex_wdata;
    logic [DATA_W-1:0]     ex_result;
    logic [4:0]            ex_rd;

    logic                  wb_valid;
    logic                  wb_ready;
    logic [DATA_W-1:0]     wb_data;
    logic [4:0]            wb_rd;
    logic                  misalign;

    logic                  mem_ce;
    logic                  mem_re;
    logic [DATA_W/8-1:0]   mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_rdatavalid;
    logic                  mem_wdatavalid;

    modport master (
        input  ex_valid, ex_load, ex_store, ex_funct3, ex_addr, ex_wdata, ex_result, ex_rd,
        output ex_ready,
        output wb_valid, wb_data, wb_rd, misalign,
        input  wb_ready,
        output mem_ce, mem_re, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_rdatavalid, mem_wdatavalid
    );

    modport slave (
        output ex_valid, ex_load, ex_store, ex_funct3, ex_addr, ex_wdata, ex_result, ex_rd,
        input  ex_ready,
        input  wb_valid, wb_data, wb_rd, misalign,
        output wb_ready,
        input  mem_ce, mem_re, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_rdatavalid, mem_wdatavalid
    );
endinterface

// File: rtl/ysyx_22050058_lsu.sv
// Load/store unit: one instruction at a time, one-cycle memory request, aligned stores, extended loads.
// Define YSYX_22050058_MISALIGN_TRAP_EN to turn misaligned accesses into a fault response instead of a request.
module ysyx_22050058_lsu #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    ysyx_22050058_lsu_if.master   bus
);
    localparam int LANES = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t               state, state_nx;
    logic                 accept;
    logic                 mem_op;
    logic                 done;

    logic [2:0]           funct3_q;
    logic [2:0]           off_q;
    logic [ADDR_W-4:0]    line_q;
    logic [DATA_W-1:0]    wdata_q;
    logic                 is_load_q;

    logic                 wb_valid_q;
    logic [DATA_W-1:0]    wb_data_q;
    logic [4:0]           wb_rd_q;

    function automatic logic [LANES-1:0] store_mask(input logic [2:0] f3, input logic [2:0] off);
        logic [LANES-1:0] base;
        case (f3[1:0])
            2'd0:    base = LANES'(8'h01);
            2'd1:    base = LANES'(8'h03);
            2'd2:    base = LANES'(8'h0F);
            default: base = LANES'(8'hFF);
        endcase
        return base << off;
    endfunction

    function automatic logic [DATA_W-1:0] load_extract(input logic [2:0] f3, input logic [2:0] off,
                                                       input logic [DATA_W-1:0] line);
        logic [DATA_W-1:0]        s;
        logic signed [DATA_W-1:0] r;
        s = line >> {off, 3'b000};
        case (f3)
            3'b000:  r = DATA_W'($signed(s[7:0]));
            3'b100:  r = DATA_W'(s[7:0]);
            3'b001:  r = DATA_W'($signed(s[15:0]));
            3'b101:  r = DATA_W'(s[15:0]);
            3'b010:  r = DATA_W'($signed(s[31:0]));
            3'b110:  r = DATA_W'(s[31:0]);
            3'b011:  r = s;
            default: r = '0;
        endcase
        return r;
    endfunction

`ifdef YSYX_22050058_MISALIGN_TRAP_EN
    logic misalign_q;
    logic trap;

    function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] off);
        case (f3[1:0])
            2'd0:    return 1'b0;
            2'd1:    return off[0];
            2'd2:    return |off[1:0];
            default: return |off;
        endcase
    endfunction

    assign trap         = misaligned(bus.ex_funct3, bus.ex_addr[2:0]);
    assign bus.misalign = misalign_q;
`else
    assign bus.misalign = 1'b0;
`endif

    assign mem_op       = bus.ex_load | bus.ex_store;
    assign done         = is_load_q ? bus.mem_rdatavalid : bus.mem_wdatavalid;
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.wb_rd    = wb_rd_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        accept        = 1'b0;
        bus.ex_ready  = 1'b0;
        bus.mem_ce    = 1'b0;
        bus.mem_re    = 1'b0;
        bus.mem_we    = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state)
            IDLE: begin
                bus.ex_ready = !rst && (!wb_valid_q || bus.wb_ready);
                accept       = bus.ex_valid && bus.ex_ready;
                if (accept && mem_op) begin
`ifdef YSYX_22050058_MISALIGN_TRAP_EN
                    state_nx = trap ? RESP : REQ;
`else
                    state_nx = REQ;
`endif
                end
            end
            REQ: begin
                bus.mem_ce   = 1'b1;
                bus.mem_re   = is_load_q;
                bus.mem_addr = {line_q, 3'b000};
                if (!is_load_q) begin
                    bus.mem_we    = store_mask(funct3_q, off_q);
                    bus.mem_wdata = wdata_q << {off_q, 3'b000};
                end
                state_nx = WAIT;
            end
            WAIT: if (done) state_nx = RESP;
            RESP: if (bus.wb_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request context, captured on accept and only consumed while a memory op is in flight
    always_ff @(posedge clk) begin
        if (accept) begin
            funct3_q  <= bus.ex_funct3;
            off_q     <= bus.ex_addr[2:0];
            line_q    <= bus.ex_addr[ADDR_W-1:3];
            wdata_q   <= bus.ex_wdata;
            is_load_q <= bus.ex_load;
        end
    end

    // Write-back register: visible outputs, so cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
`ifdef YSYX_22050058_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (wb_valid_q && bus.wb_ready) wb_valid_q <= 1'b0;
                    if (accept) begin
                        wb_rd_q <= bus.ex_rd;
`ifdef YSYX_22050058_MISALIGN_TRAP_EN
                        misalign_q <= 1'b0;
                        if (mem_op && trap) begin
                            wb_valid_q <= 1'b1;
                            misalign_q <= 1'b1;
                            wb_data_q  <= DATA_W'(bus.ex_addr);
                        end
`endif
                        if (!mem_op) begin
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= bus.ex_result;
                        end
                    end
                end
                WAIT: begin
                    if (done) begin
                        wb_valid_q <= 1'b1;
                        wb_data_q  <= is_load_q ? load_extract(funct3_q, off_q, bus.mem_rdata) : '0;
                    end
                end
                RESP: if (bus.wb_ready) wb_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22050058_lsu.sv
// Randomized self-checking bench for ysyx_22050058_lsu against a byte-level reference model.
module tb_ysyx_22050058_lsu;
    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    ysyx_22050058_lsu_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    ysyx_22050058_lsu #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    // Bytes at offset..offset+size-1 of the line; bytes past the line end read as zero
    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [2:0] off, input logic [63:0] line);
        logic [63:0] v;
        int sz;
        int o;
        v  = '0;
        sz = acc_size(f3);
        o  = int'(off);
        if (f3 == 3'b111) return '0;
        for (int i = 0; i < sz; i++)
            if (o + i < 8) v[8*i +: 8] = line[8*(o+i) +: 8];
        if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | ~((64'd1 << (8*sz)) - 64'd1);
        return v;
    endfunction

    function automatic logic [7:0] ref_mask(input logic [2:0] f3, input logic [2:0] off);
        logic [15:0] m;
        m = 16'((32'd1 << acc_size(f3)) - 32'd1) << off;
        return m[7:0];
    endfunction

    function automatic logic [63:0] ref_wdata(input logic [2:0] off, input logic [63:0] wd);
        logic [63:0] r;
        int o;
        r = '0;
        o = int'(off);
        for (int j = 0; j < 8; j++)
            if (j >= o) r[8*j +: 8] = wd[8*(j-o) +: 8];
        return r;
    endfunction

    task automatic idle_inputs();
        bus.ex_valid       = 1'b0;
        bus.ex_load        = 1'b0;
        bus.ex_store       = 1'b0;
        bus.mem_rdatavalid = 1'b0;
        bus.mem_wdatavalid = 1'b0;
    endtask

    task automatic mem_op(input bit load, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [63:0] line, input logic [4:0] rd,
                          input int lat, input int stall);
        bit          trap;
        logic [63:0] exp_data;
        trap = 1'b0;
`ifdef YSYX_22050058_MISALIGN_TRAP_EN
        trap = (addr % 64'(acc_size(f3))) != 0;
`endif
        exp_data = trap ? addr : (load ? ref_load(f3, addr[2:0], line) : 64'd0);

        @(negedge clk);
        bus.wb_ready  = (stall == 0);
        bus.ex_valid  = 1'b1;
        bus.ex_load   = load;
        bus.ex_store  = !load;
        bus.ex_funct3 = f3;
        bus.ex_addr   = addr;
        bus.ex_wdata  = wdata;
        bus.ex_result = {$urandom, $urandom};
        bus.ex_rd     = rd;
        #1 check("accept_ready", 64'(bus.ex_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.ex_valid  = 1'b0;
        bus.ex_addr   = {$urandom, $urandom};
        bus.ex_wdata  = {$urandom, $urandom};
        bus.mem_rdata = {$urandom, $urandom};
        if (trap) begin
            check("trap_no_ce", 64'(bus.mem_ce), 64'd0);
        end else begin
            check("req_ce",    64'(bus.mem_ce), 64'd1);
            check("req_re",    64'(bus.mem_re), 64'(load));
            check("req_we",    64'(bus.mem_we), load ? 64'd0 : 64'(ref_mask(f3, addr[2:0])));
            check("req_addr",  bus.mem_addr, addr & ~64'h7);
            check("req_wdata", bus.mem_wdata, load ? 64'd0 : ref_wdata(addr[2:0], wdata));
            check("req_busy",  64'(bus.ex_ready), 64'd0);
            for (int k = 0; k <= lat; k++) begin
                @(negedge clk);
                bus.mem_rdatavalid = 1'b0;
                bus.mem_wdatavalid = 1'b0;
                check("wait_ce",    64'(bus.mem_ce), 64'd0);
                check("wait_valid", 64'(bus.wb_valid), 64'd0);
                if (k == lat) begin
                    bus.mem_rdata      = line;
                    bus.mem_rdatavalid = load;
                    bus.mem_wdatavalid = !load;
                end
            end
            @(posedge clk);
            @(negedge clk);
            bus.mem_rdatavalid = 1'b0;
            bus.mem_wdatavalid = 1'b0;
            bus.mem_rdata      = {$urandom, $urandom};
        end
        #1;
        check("resp_valid", 64'(bus.wb_valid), 64'd1);
        check("resp_data",  bus.wb_data, exp_data);
        check("resp_rd",    64'(bus.wb_rd), 64'(rd));
        check("resp_misal", 64'(bus.misalign), 64'(trap));
        check("resp_busy",  64'(bus.ex_ready), 64'd0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("hold_valid", 64'(bus.wb_valid), 64'd1);
            check("hold_data",  bus.wb_data, exp_data);
            check("hold_busy",  64'(bus.ex_ready), 64'd0);
        end
        bus.wb_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("done_valid", 64'(bus.wb_valid), 64'd0);
        check("done_ready", 64'(bus.ex_ready), 64'd1);
    endtask

    task automatic pass_burst(input int n);
        logic [63:0] dq[$];
        logic [4:0]  rq[$];
        logic [63:0] d;
        logic [4:0]  r;
        bus.wb_ready = 1'b1;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            #1;
            if (i > 0) begin
                check("pt_valid", 64'(bus.wb_valid), 64'd1);
                check("pt_data",  bus.wb_data, dq.pop_front());
                check("pt_rd",    64'(bus.wb_rd), 64'(rq.pop_front()));
            end
            if (i < n) begin
                d = {$urandom, $urandom};
                r = 5'($urandom_range(1, 31));
                bus.ex_valid  = 1'b1;
                bus.ex_load   = 1'b0;
                bus.ex_store  = 1'b0;
                bus.ex_result = d;
                bus.ex_rd     = r;
                check("pt_ready", 64'(bus.ex_ready), 64'd1);
                dq.push_back(d);
                rq.push_back(r);
            end else begin
                bus.ex_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("pt_drain", 64'(bus.wb_valid), 64'd0);
    endtask

    bit          ld;
    logic [2:0]  f3;
    logic [63:0] addr, wd, line;

    initial begin
        idle_inputs();
        bus.wb_ready  = 1'b0;
        bus.ex_funct3 = '0;
        bus.ex_addr   = '0;
        bus.ex_wdata  = '0;
        bus.ex_result = '0;
        bus.ex_rd     = '0;
        bus.mem_rdata = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready",  64'(bus.ex_ready), 64'd0);
        check("rst_valid",  64'(bus.wb_valid), 64'd0);
        check("rst_data",   bus.wb_data, 64'd0);
        check("rst_rd",     64'(bus.wb_rd), 64'd0);
        check("rst_misal",  64'(bus.misalign), 64'd0);
        check("rst_ce",     64'(bus.mem_ce), 64'd0);
        check("rst_re",     64'(bus.mem_re), 64'd0);
        check("rst_we",     64'(bus.mem_we), 64'd0);
        check("rst_addr",   bus.mem_addr, 64'd0);
        check("rst_wdata",  bus.mem_wdata, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(bus.ex_ready), 64'd1);

        mem_op(1'b1, 3'b000, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 5'd5, 0, 0);
        mem_op(1'b0, 3'b001, 64'h8000_0006, 64'h1234, 64'd0, 5'd6, 0, 0);
        mem_op(1'b1, 3'b110, 64'h8000_0104, 64'd0, {32'h8765_4321, $urandom}, 5'd7, 1, 5);
        mem_op(1'b1, 3'b010, 64'h8000_0002, 64'd0, {$urandom, $urandom}, 5'd8, 0, 0);

        pass_burst(3);

        // Pass-through result held back by WB blocks the next accept
        @(negedge clk);
        bus.wb_ready  = 1'b0;
        bus.ex_valid  = 1'b1;
        bus.ex_result = 64'hDEAD_BEEF_0000_0001;
        bus.ex_rd     = 5'd9;
        @(posedge clk);
        @(negedge clk);
        bus.ex_valid = 1'b0;
        #1;
        check("pt_stall_valid", 64'(bus.wb_valid), 64'd1);
        check("pt_stall_ready", 64'(bus.ex_ready), 64'd0);
        check("pt_stall_data",  bus.wb_data, 64'hDEAD_BEEF_0000_0001);
        bus.wb_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("pt_stall_clear", 64'(bus.wb_valid), 64'd0);

        // Completion pulses while idle are ignored
        bus.mem_rdatavalid = 1'b1;
        bus.mem_wdatavalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        #1;
        check("stray_valid", 64'(bus.wb_valid), 64'd0);
        check("stray_ready", 64'(bus.ex_ready), 64'd1);

        // Reset while waiting for memory drops the response
        bus.ex_valid  = 1'b1;
        bus.ex_load   = 1'b1;
        bus.ex_funct3 = 3'b011;
        bus.ex_addr   = 64'h8000_0010;
        bus.ex_rd     = 5'd3;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        check("rw_wait_ce", 64'(bus.mem_ce), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rw_rst_ready", 64'(bus.ex_ready), 64'd0);
        rst = 1'b0;
        bus.mem_rdatavalid = 1'b1;
        bus.mem_rdata      = 64'h1111_2222_3333_4444;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        #1;
        check("rw_valid", 64'(bus.wb_valid), 64'd0);
        check("rw_ready", 64'(bus.ex_ready), 64'd1);
        check("rw_ce",    64'(bus.mem_ce), 64'd0);

        for (int n = 0; n < 40; n++) begin
            ld   = 1'($urandom_range(0, 1));
            f3   = ld ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
            addr = 64'h8000_0000 + 64'($urandom_range(0, 4095));
            wd   = {$urandom, $urandom};
            line = {$urandom, $urandom};
            mem_op(ld, f3, addr, wd, line, 5'($urandom_range(0, 31)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            if (n % 10 == 9) pass_burst(int'($urandom_range(1, 4)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
